// File: rtl/char_dot_shifter_pkg.sv
// Shared types and helpers for the character dot serializer.
`include "char_dot_defs.vh"

package char_dot_shifter_pkg;

  localparam int unsigned DOT_CNT_W   = 4;
  localparam int unsigned BLINK_CNT_W = 8;

  // What the cell datapath does on a given clk edge.
  typedef enum logic [1:0] {
    CELL_HOLD  = 2'd0,
    CELL_SYNC  = 2'd1,
    CELL_LOAD  = 2'd2,
    CELL_SHIFT = 2'd3
  } cell_op_e;

  // Source of the pattern latched into the shift register on a load edge.
  typedef enum logic [1:0] {
    SRC_BLANK  = 2'd0,
    SRC_CURSOR = 2'd1,
    SRC_GLYPH  = 2'd2
  } load_src_e;

  // Blanking wins over the cursor; the cursor only shows in its visible phase.
  function automatic load_src_e pick_load_src(input logic blank_i,
                                              input logic cursor_here_i,
                                              input logic blink_phase_i);
    load_src_e src;
    if (blank_i) begin
      src = SRC_BLANK;
    end else if (cursor_here_i && blink_phase_i) begin
      src = SRC_CURSOR;
    end else begin
      src = SRC_GLYPH;
    end
    return src;
  endfunction

  // Edge classification: line_sync beats dot_en, and the last slot turns dot_en into a load.
  function automatic cell_op_e pick_cell_op(input logic line_sync_i,
                                            input logic dot_en_i,
                                            input logic at_last_slot_i);
    cell_op_e op;
    op = CELL_HOLD;
    if (line_sync_i) begin
      op = CELL_SYNC;
    end else if (dot_en_i) begin
      op = at_last_slot_i ? CELL_LOAD : CELL_SHIFT;
    end
    return op;
  endfunction

endpackage

// File: rtl/char_dot_defs.vh
// Cell geometry and blink rate shared by the character-ROM, video-timing and dot-serializer stages.
`ifndef CHAR_DOT_DEFS_VH
`define CHAR_DOT_DEFS_VH

`define CHAR_W_DEF       7
`define GLYPH_W_DEF      5
`define BLINK_FRAMES_DEF 16

`endif

// File: rtl/char_dot_shifter_blink_timer.sv
// Cursor blink timer: toggles the visible phase every BLINK_FRAMES frame_sync pulses.
`include "char_dot_defs.vh"

module blink_timer
  import char_dot_shifter_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = `BLINK_FRAMES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_sync,
  output logic blink_phase
);

  localparam logic [BLINK_CNT_W-1:0] LAST_FRAME = BLINK_CNT_W'(BLINK_FRAMES - 1);

  logic [BLINK_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_sync) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BLINK_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/char_dot_shifter.sv
// Dot serializer: latches one glyph row per cell, shifts it out MSB-first with blanking and cursor.
`include "char_dot_defs.vh"

module char_dot_shifter
  import char_dot_shifter_pkg::*;
#(
  parameter int unsigned CHAR_W       = `CHAR_W_DEF,
  parameter int unsigned GLYPH_W      = `GLYPH_W_DEF,
  parameter int unsigned BLINK_FRAMES = `BLINK_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dot_en,
  input  logic               line_sync,
  input  logic               frame_sync,
  input  logic [GLYPH_W-1:0] glyph_row,
  input  logic               cursor_here,
  input  logic               blank,
  output logic               next_char,
  output logic               video_dot,
  output logic               blink_phase,
  output logic [3:0]         dot_cnt
);

  localparam int unsigned            GAP_W     = CHAR_W - GLYPH_W;
  localparam logic [DOT_CNT_W-1:0]   LAST_SLOT = DOT_CNT_W'(CHAR_W - 1);

  logic [DOT_CNT_W-1:0] dot_cnt_q, dot_cnt_d;
  logic [CHAR_W-1:0]    sr_q, sr_d;
  logic                 video_dot_q, video_dot_d;
  logic                 next_char_q, next_char_d;
  logic                 blink_phase_w;

  logic [CHAR_W-1:0]    load_c;
  cell_op_e             op_c;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_sync (frame_sync),
    .blink_phase(blink_phase_w)
  );

  // Load pattern; uses the registered (pre-toggle) blink phase so a cell never changes mid-way.
  always_comb begin
    load_c = '0;
    case (pick_load_src(blank, cursor_here, blink_phase_w))
      SRC_BLANK:  load_c = '0;
      SRC_CURSOR: load_c = {{GLYPH_W{1'b1}}, {GAP_W{1'b0}}};
      default:    load_c = {glyph_row, {GAP_W{1'b0}}};
    endcase
  end

  always_comb begin
    op_c = pick_cell_op(line_sync, dot_en, dot_cnt_q == LAST_SLOT);
  end

  // Next-state for the slot counter, shift register, dot and advance strobe.
  always_comb begin
    dot_cnt_d   = dot_cnt_q;
    sr_d        = sr_q;
    video_dot_d = video_dot_q;
    next_char_d = 1'b0;
    case (op_c)
      CELL_SYNC: begin
        dot_cnt_d   = LAST_SLOT;
        sr_d        = '0;
        video_dot_d = 1'b0;
      end
      CELL_LOAD: begin
        dot_cnt_d   = '0;
        video_dot_d = load_c[CHAR_W-1];
        sr_d        = {load_c[CHAR_W-2:0], 1'b0};
        next_char_d = 1'b1;
      end
      CELL_SHIFT: begin
        dot_cnt_d   = dot_cnt_q + DOT_CNT_W'(1);
        video_dot_d = sr_q[CHAR_W-1];
        sr_d        = {sr_q[CHAR_W-2:0], 1'b0};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dot_cnt_q   <= LAST_SLOT;
      sr_q        <= '0;
      video_dot_q <= 1'b0;
      next_char_q <= 1'b0;
    end else begin
      dot_cnt_q   <= dot_cnt_d;
      sr_q        <= sr_d;
      video_dot_q <= video_dot_d;
      next_char_q <= next_char_d;
    end
  end

  assign dot_cnt     = dot_cnt_q;
  assign video_dot   = video_dot_q;
  assign next_char   = next_char_q;
  assign blink_phase = blink_phase_w;

endmodule

// File: tb/tb_char_dot_shifter.sv
// Bench for char_dot_shifter: directed cell scenarios plus random traffic against a cell-level model.
module tb_char_dot_shifter;

  localparam int unsigned CW = 7;
  localparam int unsigned GW = 5;
  localparam int unsigned BF = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dot_en;
  logic          line_sync;
  logic          frame_sync;
  logic [GW-1:0] glyph_row;
  logic          cursor_here;
  logic          blank;
  logic          next_char;
  logic          video_dot;
  logic          blink_phase;
  logic [3:0]    dot_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  char_dot_shifter #(
    .CHAR_W      (CW),
    .GLYPH_W     (GW),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dot_en     (dot_en),
    .line_sync  (line_sync),
    .frame_sync (frame_sync),
    .glyph_row  (glyph_row),
    .cursor_here(cursor_here),
    .blank      (blank),
    .next_char  (next_char),
    .video_dot  (video_dot),
    .blink_phase(blink_phase),
    .dot_cnt    (dot_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cell-level model: each load builds the list of dots for the cell, slot k shows entry k.
  int m_slot;
  bit m_cell[CW];
  bit m_dot;
  bit m_next;
  int m_frames;

  always @(posedge clk) begin
    bit ph;
    if (!reset_n) begin
      m_slot   = CW - 1;
      m_dot    = 1'b0;
      m_next   = 1'b0;
      m_frames = 0;
    end else begin
      ph = ((m_frames / BF) % 2) == 1;
      if (frame_sync) m_frames++;
      if (line_sync) begin
        m_slot = CW - 1;
        m_dot  = 1'b0;
        m_next = 1'b0;
      end else if (dot_en) begin
        if (m_slot == CW - 1) begin
          for (int k = 0; k < CW; k++) begin
            if (blank || k >= GW)          m_cell[k] = 1'b0;
            else if (cursor_here && ph)    m_cell[k] = 1'b1;
            else                           m_cell[k] = glyph_row[GW-1-k];
          end
          m_slot = 0;
          m_next = 1'b1;
        end else begin
          m_slot++;
          m_next = 1'b0;
        end
        m_dot = m_cell[m_slot];
      end else begin
        m_next = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_dot_cnt",     32'(dot_cnt),     32'(m_slot));
      check("model_video_dot",   32'(video_dot),   32'(m_dot));
      check("model_next_char",   32'(next_char),   32'(m_next));
      check("model_blink_phase", 32'(blink_phase), 32'((m_frames / BF) % 2));
    end
  end

  task automatic step(input bit en, input bit ls = 1'b0, input bit fs = 1'b0);
    @(negedge clk);
    dot_en     = en;
    line_sync  = ls;
    frame_sync = fs;
  endtask

  // One dot_en edge; returns after the following negedge with outputs settled.
  task automatic dot_edge(input bit ls = 1'b0, input bit fs = 1'b0);
    step(1'b1, ls, fs);
    step(1'b0);
  endtask

  task automatic frame_pulse();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0);
  endtask

  // A whole cell, dot_en every 4 clks; optionally flips blank after slot flip_at.
  task automatic run_cell(input string tag, input logic [CW-1:0] exp_dots,
                          input int flip_at = -1, input bit fs_on_load = 1'b0);
    for (int k = 0; k < CW; k++) begin
      dot_edge(1'b0, (k == 0) ? fs_on_load : 1'b0);
      check({tag, "_dot"},     32'(video_dot), 32'(exp_dots[CW-1-k]));
      check({tag, "_next"},    32'(next_char), (k == 0) ? 32'd1 : 32'd0);
      check({tag, "_dot_cnt"}, 32'(dot_cnt),   32'(k));
      if (k == flip_at) blank = ~blank;
      step(1'b0);
      step(1'b0);
    end
  endtask

  initial begin
    int last;
    int pulses;
    reset_n     = 1'b0;
    dot_en      = 1'b0;
    line_sync   = 1'b0;
    frame_sync  = 1'b0;
    glyph_row   = 5'b10110;
    cursor_here = 1'b0;
    blank       = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_dot_cnt",     32'(dot_cnt),     32'd6);
    check("reset_video_dot",   32'(video_dot),   32'd0);
    check("reset_next_char",   32'(next_char),   32'd0);
    check("reset_blink_phase", 32'(blink_phase), 32'd0);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    run_cell("first", 7'b1011000);

    glyph_row = 5'b11111;
    blank     = 1'b1;
    run_cell("blank", 7'b0000000, 2);
    run_cell("unblank", 7'b1111100, 3);
    blank = 1'b0;

    glyph_row   = 5'b00000;
    cursor_here = 1'b1;
    frame_pulse();
    check("blink_after_fs1", 32'(blink_phase), 32'd0);
    frame_pulse();
    check("blink_after_fs2", 32'(blink_phase), 32'd1);
    run_cell("cursor_on", 7'b1111100);
    frame_pulse();
    check("blink_after_fs3", 32'(blink_phase), 32'd1);
    frame_pulse();
    check("blink_after_fs4", 32'(blink_phase), 32'd0);
    run_cell("cursor_off", 7'b0000000);
    frame_pulse();
    run_cell("cursor_fs_on_load", 7'b0000000, -1, 1'b1);
    check("blink_after_fs6", 32'(blink_phase), 32'd1);
    run_cell("cursor_on2", 7'b1111100);
    cursor_here = 1'b0;

    glyph_row = 5'b10110;
    repeat (3) dot_edge();
    check("ls_pre_dot_cnt", 32'(dot_cnt), 32'd2);
    dot_edge(1'b1);
    check("ls_dot_cnt",   32'(dot_cnt),   32'd6);
    check("ls_video_dot", 32'(video_dot), 32'd0);
    check("ls_next_char", 32'(next_char), 32'd0);
    dot_edge();
    check("ls_reload_dot_cnt", 32'(dot_cnt),   32'd0);
    check("ls_reload_dot",     32'(video_dot), 32'd1);
    check("ls_reload_next",    32'(next_char), 32'd1);
    repeat (CW - 1) dot_edge();

    glyph_row = 5'b11111;
    repeat (3) dot_edge();
    check("rst_mid_pre_dot", 32'(video_dot), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    dot_en  = 1'b1;
    @(negedge clk);
    check("rst_mid_video_dot", 32'(video_dot), 32'd0);
    check("rst_mid_next_char", 32'(next_char), 32'd0);
    check("rst_mid_dot_cnt",   32'(dot_cnt),   32'd6);
    reset_n = 1'b1;
    dot_en  = 1'b0;
    dot_edge();
    check("rst_reload_dot_cnt", 32'(dot_cnt),   32'd0);
    check("rst_reload_next",    32'(next_char), 32'd1);
    check("rst_reload_dot",     32'(video_dot), 32'd1);
    repeat (CW - 1) dot_edge();

    glyph_row = 5'b10011;
    last      = -1;
    pulses    = 0;
    @(negedge clk);
    dot_en = 1'b1;
    for (int i = 0; i < 100 * CW; i++) begin
      @(negedge clk);
      if (next_char) begin
        if (last >= 0) check("cont_spacing", 32'(i - last), 32'(CW));
        last = i;
        pulses++;
      end
    end
    dot_en = 1'b0;
    check("cont_pulses", 32'(pulses), 32'd100);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_n     = ($urandom_range(0, 299) != 0);
      dot_en      = ($urandom_range(0, 1) == 1);
      line_sync   = ($urandom_range(0, 49) == 0);
      frame_sync  = ($urandom_range(0, 9) == 0);
      glyph_row   = GW'($urandom);
      cursor_here = ($urandom_range(0, 3) == 0);
      blank       = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    dot_en     = 1'b0;
    line_sync  = 1'b0;
    frame_sync = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_dot_shifter.md
Name: char_dot_shifter

Overview:
- Dot serializer for the video terminal.
- Latches one 5-bit glyph row per character cell from the character-ROM stage and shifts it out MSB-first, one dot per dot-clock enable.
- Applies blanking and the blinking block cursor, then drives the registered dot into the downstream video gating/mixing logic.
- Also generates the per-character advance strobe and the cursor blink phase.

Parameters:
- CHAR_W, 7, dots per character cell (glyph plus inter-character gap); valid range GLYPH_W+1 .. 15
- GLYPH_W, 5, glyph row width in dots
- BLINK_FRAMES, 16, frames per blink half-period; valid range 2 .. 255

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- dot_en  in  1  one-clk dot-clock enable; one dot per pulse
- line_sync  in  1  one-clk pulse at start of each scan line; realigns the cell counter
- frame_sync  in  1  one-clk pulse per video frame; advances the blink timer
- glyph_row  in  GLYPH_W  glyph row bits for the current cell, bit GLYPH_W-1 = leftmost dot
- cursor_here  in  1  current cell holds the cursor
- blank  in  1  current cell is outside the active area
- next_char  out  1  one-clk pulse; upstream advances to the next cell's data
- video_dot  out  1  registered dot output
- blink_phase  out  1  cursor visible phase
- dot_cnt  out  4  current dot slot within the cell, 0 .. CHAR_W-1

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values: dot_cnt = CHAR_W-1, sr = 0, video_dot = 0, next_char = 0, blink_phase = 0, blink counter = 0. Reset asserted mid-cell aborts the cell immediately; the first dot_en after release is a load edge.
- Load edge: a clk edge with dot_en=1 and dot_cnt=CHAR_W-1.
  - glyph_row, cursor_here and blank are sampled on this edge only. Upstream holds them stable through it.
  - Load value L (CHAR_W bits):
    - if blank: L = 0;
    - else if cursor_here and blink_phase: L = GLYPH_W ones, then zeros;
    - else: L = glyph_row, then (CHAR_W-GLYPH_W) zeros.
  - blank overrides the cursor.
  - On the load edge: video_dot <= L[CHAR_W-1]; sr <= L << 1; dot_cnt <= 0; next_char <= 1 on the following cycle, for exactly one clk.
- Shift edge: dot_en=1 and dot_cnt<CHAR_W-1. video_dot <= sr[CHAR_W-1]; sr <= sr << 1; dot_cnt <= dot_cnt+1.
- dot_en=0: all state holds, and next_char returns to 0.
- Latency and timing:
  - video_dot is valid one clk after the dot_en edge of its slot and holds until the next dot_en edge.
  - Slot k (0 .. GLYPH_W-1) shows glyph bit GLYPH_W-1-k.
  - Gap slots always output 0.
- Upstream timing budget: upstream has CHAR_W-1 dot periods after next_char to present the next cell's data.
- line_sync:
  - Priority over dot_en on the same edge: dot_cnt <= CHAR_W-1, sr <= 0, video_dot <= 0, next_char <= 0.
  - The next dot_en is therefore a load edge.
- Blink timer:
  - frame_sync increments an 8-bit counter.
  - When the counter reaches BLINK_FRAMES-1 and frame_sync is high: counter <= 0 and blink_phase toggles.
  - frame_sync coinciding with a load edge: the load uses the pre-toggle blink_phase.
  - blink_phase changes are visible from the next load edge onward, never mid-cell.
- Widths: dot_cnt is 4 bits and compares against CHAR_W-1 as an unsigned value; there is no wrap beyond CHAR_W-1.

Decomposition:
- Shared include file (char_dot_defs.vh) holds `define constants CHAR_W_DEF=7, GLYPH_W_DEF=5 and BLINK_FRAMES_DEF=16, shared with the character-ROM and video-timing stages.
- One sub-module: blink_timer (frame_sync in; blink_phase out; BLINK_FRAMES parameter).
- The shifter, counter and load mux stay in char_dot_shifter.

Test Plan:
- Reset and first cell: assert reset_n=0 for 3 clks, then release; dot_en every 4 clks; glyph_row=5'b10110, cursor_here=0, blank=0 → video_dot over successive slots = 1,0,1,1,0,0,0; next_char high for exactly 1 clk, the clk after each load edge, once per 7 dot_en.
- Blanking: blank=1 with glyph_row=5'b11111 → 7 slots of video_dot=0. Toggle blank mid-cell → no effect until the next load edge.
- Cursor blink (BLINK_FRAMES=2): cursor_here=1, glyph_row=0, 4 frame_sync pulses → blink_phase toggles after frame_sync #2 and #4. Cells loaded while blink_phase=1 → 1,1,1,1,1,0,0; while blink_phase=0 → all 0.
- line_sync mid-cell: line_sync at slot 3 together with dot_en → dot_cnt=6 and video_dot=0 on the next clk; the following dot_en loads a new cell and outputs slot 0.
- Reset mid-operation: reset_n=0 at slot 2 of a glyph 5'b11111 cell → video_dot=0 and next_char=0 on the next clk; after release, the first dot_en is a load edge.
- dot_en held continuously high: every clk shifts one dot; next_char pulses every 7 clks with no missed or extra pulses over 100 cells.
